// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, FSM states
// and the unsupported-opcode classifier.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b111;  // ALU default select, y = 0

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    // Anything outside the six implemented encodings (110, 111) is flagged.
    function automatic logic is_unsupported(input logic [2:0] op);
        return !(op inside {OP_AND, OP_OR, OP_SHL, OP_ADD, OP_SUB, OP_MUL});
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO holding packed {op, a, b} entries; pointers wrap
// modulo DEPTH and the occupancy count is registered.
module alu_req_fifo #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count/pointers alone define
    // which entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational ALU: queues requests, drives the
// ALU from registers for one cycle, captures the result and hands it out.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [OP_W-1:0]   alu_select,
    output logic [DATA_W-1:0] alu_x1,
    output logic [DATA_W-1:0] alu_x2,
    input  logic [DATA_W-1:0] alu_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [OP_W-1:0]   out_op,
    output logic              out_err,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    req_t            req_in;
    req_t            req_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            push;
    logic            pop;
    logic            capture;
    logic            release_out;
    logic [OP_W-1:0] op_q;
    state_t          state;
    state_t          state_next;

    assign req_in   = '{op: in_op, a: in_a, b: in_b};
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign busy     = (state != ST_IDLE) || (fifo_count != '0);

    alu_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (req_in),
        .pop   (pop),
        .rdata (req_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every register update uses <= so all flops sample the same
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!fifo_empty) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = fifo_empty ? ST_IDLE : ST_EXEC;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_EXEC: capture = 1'b1;
            ST_DONE: begin
                release_out = out_ready;
                pop         = out_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    // Operand registers only change on a pop, so the ALU inputs hold their
    // last values through IDLE and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_select <= OP_W'(OP_NOP);
            alu_x1     <= '0;
            alu_x2     <= '0;
            op_q       <= '0;
        end else if (pop) begin
            alu_select <= req_head.op;
            alu_x1     <= req_head.a;
            alu_x2     <= req_head.b;
            op_q       <= req_head.op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
            out_err    <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_result <= alu_y;
            out_op     <= op_q;
            out_err    <= is_unsupported(op_q);
        end else if (release_out) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU, a result
// scoreboard checked every cycle, and hand-computed expectations per scenario.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  alu_select;
    logic [31:0] alu_x1;
    logic [31:0] alu_x2;
    logic [31:0] alu_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_op;
    logic        out_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(32), .OP_W(3), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_select (alu_select),
        .alu_x1     (alu_x1),
        .alu_x2     (alu_x2),
        .alu_y      (alu_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_err    (out_err),
        .busy       (busy)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] x1, input logic [31:0] x2);
        case (op)
            3'b000:  return x1 & x2;
            3'b001:  return x1 | x2;
            3'b010:  return (x2 >= 32) ? 32'd0 : (x1 << x2);
            3'b011:  return x1 + x2;
            3'b100:  return x1 - x2;
            3'b101:  return x1 * x2;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_y = alu_ref(alu_select, alu_x1, alu_x2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted request must come out once, in order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
        end else begin
            if (in_valid && in_ready) begin
                e.op  = in_op;
                e.res = alu_ref(in_op, in_a, in_b);
                e.err = (in_op >= 3'b110);
                exp_q.push_back(e);
            end
            if (exp_q.size() == 0) begin
                check("no_spurious_valid", out_valid, 0);
            end else if (out_valid) begin
                check("sb_result", out_result, exp_q[0].res);
                check("sb_op", out_op, exp_q[0].op);
                check("sb_err", out_err, exp_q[0].err);
                if (out_ready) e = exp_q.pop_front();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int   tries = 0;
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        while (!ok && tries < 20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    task automatic wait_result(input string name, input logic [31:0] res, input logic [2:0] op,
                               input logic err, output int waited);
        logic seen = 1'b0;
        waited = 0;
        while (!seen && waited < 30) begin
            @(negedge clk);
            waited++;
            seen = out_valid && out_ready;
        end
        check({name, "_seen"}, seen, 1);
        if (seen) begin
            check({name, "_result"}, out_result, res);
            check({name, "_op"}, out_op, op);
            check({name, "_err"}, out_err, err);
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((busy || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", busy, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int sent;
        logic acc;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_alu_select", alu_select, 3'b111);
        check("rst_alu_x1", alu_x1, 0);
        check("rst_alu_x2", alu_x2, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_op", out_op, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // 1: single ADD, latency N+3
        push(3'b011, 6, 3);
        @(negedge clk);
        check("t1_idle_valid", out_valid, 0);
        @(negedge clk);
        check("t1_exec_x1", alu_x1, 6);
        check("t1_exec_x2", alu_x2, 3);
        check("t1_exec_sel", alu_select, 3'b011);
        check("t1_exec_valid", out_valid, 0);
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_result", out_result, 9);
        check("t1_op", out_op, 3'b011);
        check("t1_err", out_err, 0);
        step();
        drain();

        // 2: back-to-back ops, one result every 2 cycles
        fork
            begin
                push(3'b000, 6, 3);
                push(3'b001, 6, 3);
                push(3'b010, 6, 3);
                push(3'b100, 6, 3);
                push(3'b101, 6, 3);
            end
            begin
                wait_result("t2_and", 2, 3'b000, 0, w);
                wait_result("t2_or", 7, 3'b001, 0, w);
                check("t2_gap_or", w, 2);
                wait_result("t2_shl", 48, 3'b010, 0, w);
                check("t2_gap_shl", w, 2);
                wait_result("t2_sub", 3, 3'b100, 0, w);
                check("t2_gap_sub", w, 2);
                wait_result("t2_mul", 18, 3'b101, 0, w);
                check("t2_gap_mul", w, 2);
            end
        join
        step();
        drain();

        // 3: unsupported opcode
        push(3'b110, 6, 3);
        wait_result("t3_unsup", 0, 3'b110, 1, w);
        step();
        drain();

        // 4: fill with output stalled, then drain in order
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 12 && sent < 7; c++) begin
            in_valid = 1'b1;
            in_op    = 3'b011;
            in_a     = 10 + sent;
            in_b     = sent;
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("t4_accepted", sent, 5);
        check("t4_full_ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_ready_before_pop", in_ready, 0);
        check("t4_first_valid", out_valid, 1);
        check("t4_first_result", out_result, 10);
        @(negedge clk);
        check("t4_ready_after_pop", in_ready, 1);
        for (int i = 1; i < 5; i++) begin
            wait_result("t4_drain", 10 + 2 * i, 3'b011, 0, w);
        end
        step();
        drain();

        // 5: output stall holds result and blocks the next pop
        out_ready = 1'b0;
        push(3'b011, 100, 1);
        push(3'b011, 200, 2);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check("t5_valid", out_valid, 1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("t5_hold_result", out_result, 101);
            check("t5_hold_op", out_op, 3'b011);
            check("t5_hold_valid", out_valid, 1);
            check("t5_no_pop", alu_x1, 100);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_next_exec_x1", alu_x1, 200);
        check("t5_next_exec_x2", alu_x2, 2);
        check("t5_exec_valid", out_valid, 0);
        wait_result("t5_next", 202, 3'b011, 0, w);
        step();
        drain();

        // 6: reset mid-EXEC with three requests queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(3'b011, i + 1, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_done_valid", out_valid, 1);
        @(negedge clk);
        check("t6_exec_x1", alu_x1, 2);
        check("t6_exec_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_sel", alu_select, 3'b111);
        check("t6_rst_x1", alu_x1, 0);
        check("t6_rst_x2", alu_x2, 0);
        check("t6_rst_result", out_result, 0);
        check("t6_rst_op", out_op, 0);
        check("t6_rst_err", out_err, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("t6_quiet_valid", out_valid, 0);
            check("t6_quiet_busy", busy, 0);
        end
        step();
        push(3'b011, 5, 5);
        wait_result("t6_after", 10, 3'b011, 0, w);
        step();
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
